// File: rtl/clk_enable_gen.sv
// -----------------------------------------------------------------------------
// clk_enable_gen
//   Multi-channel, runtime-programmable clock-enable generator. Each channel
//   divides the system clock by its own divisor D. It produces two outputs:
//     - a one-cycle tick at the start of every period
//     - a square wave that is high for ceil(D/2) cycles and low for floor(D/2)
//   A new divisor is held as pending and only becomes active at a period
//   boundary, so no period is ever truncated or stretched. A global sync
//   restarts every channel together.
//
//   Optional feature: CLKGEN_PHASE_EN. When this macro is defined, each write
//   also carries a phase. On sync, that phase is loaded into the counter, so
//   the channels can be skewed against each other.
//
// Ports
//   clk_in          system clock
//   rst_in          asynchronous, active-high reset
//   cfg_valid_in    a divisor write is offered
//   cfg_ready_out   the write can be accepted this cycle (combinational)
//   cfg_ch_in       target channel of the write
//   cfg_div_in      new divisor; values below 2 are clamped to 2
//   cfg_phase_in    sync phase for the channel (only with CLKGEN_PHASE_EN)
//   sync_in         realign all channels
//   tick_out        per-channel period-start strobe (registered)
//   clk_out         per-channel square wave (registered)
// -----------------------------------------------------------------------------

// Per-channel divider: active/pending divisor pair, period counter, outputs.
module clk_enable_ch #(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             sync_i,
  input  logic             wr_i,       // accepted write targeting this channel
  input  logic [DIV_W-1:0] wr_div_i,   // already clamped to >= 2
`ifdef CLKGEN_PHASE_EN
  input  logic [DIV_W-1:0] wr_phase_i,
`endif
  output logic             tick_o,
  output logic             clk_o,
  output logic             pend_o
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] div_pend_q, div_pend_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             clk_q, clk_d;
  logic             wrap;
  logic [DIV_W:0]   half;  // ceil(D'/2); one extra bit so D = 2^DIV_W-1 cannot overflow
`ifdef CLKGEN_PHASE_EN
  logic [DIV_W-1:0] phase_q, phase_d;
  logic [DIV_W-1:0] phase_pend_q, phase_pend_d;
`endif

  assign wrap = (cnt_q == div_q - DIV_W'(1));

  always_comb begin
    div_d      = div_q;
    div_pend_d = div_pend_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q + DIV_W'(1);
`ifdef CLKGEN_PHASE_EN
    phase_d      = phase_q;
    phase_pend_d = phase_pend_q;
`endif
    // A period boundary, or a sync, is the only place a pending divisor
    // becomes active.
    if (sync_i || wrap) begin
      cnt_d = '0;
      if (pend_q) begin
        div_d  = div_pend_q;
        pend_d = 1'b0;
`ifdef CLKGEN_PHASE_EN
        phase_d = phase_pend_q;
`endif
      end
    end
`ifdef CLKGEN_PHASE_EN
    // The sync phase is checked against the divisor in force after this edge.
    if (sync_i) cnt_d = (phase_d >= div_d) ? '0 : phase_d;
`endif
    // A write is only accepted while nothing is pending. So it never collides
    // with an apply above. A write on a wrap or sync edge waits for the next
    // boundary.
    if (wr_i) begin
      pend_d     = 1'b1;
      div_pend_d = wr_div_i;
`ifdef CLKGEN_PHASE_EN
      phase_pend_d = wr_phase_i;
`endif
    end
    half   = ({1'b0, div_d} + (DIV_W+1)'(1)) >> 1;
    tick_d = (cnt_d == '0);
    clk_d  = ({1'b0, cnt_d} < half);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      div_q      <= DIV_W'(DEFAULT_DIV);
      cnt_q      <= DIV_W'(DEFAULT_DIV - 1);  // first edge after reset wraps -> tick
      div_pend_q <= '0;
      pend_q     <= 1'b0;
      tick_q     <= 1'b0;
      clk_q      <= 1'b0;
`ifdef CLKGEN_PHASE_EN
      phase_q      <= '0;
      phase_pend_q <= '0;
`endif
    end else begin
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      div_pend_q <= div_pend_d;
      pend_q     <= pend_d;
      tick_q     <= tick_d;
      clk_q      <= clk_d;
`ifdef CLKGEN_PHASE_EN
      phase_q      <= phase_d;
      phase_pend_q <= phase_pend_d;
`endif
    end
  end

  assign tick_o = tick_q;
  assign clk_o  = clk_q;
  assign pend_o = pend_q;

endmodule

module clk_enable_gen #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 4,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              cfg_valid_in,
  output logic              cfg_ready_out,
  input  logic [CH_W-1:0]   cfg_ch_in,
  input  logic [DIV_W-1:0]  cfg_div_in,
`ifdef CLKGEN_PHASE_EN
  input  logic [DIV_W-1:0]  cfg_phase_in,
`endif
  input  logic              sync_in,
  output logic [NUM_CH-1:0] tick_out,
  output logic [NUM_CH-1:0] clk_out
);

  logic [NUM_CH-1:0] pend;
  logic [DIV_W-1:0]  div_clamped;
  logic              cfg_acc;

  // Writes to a channel index that does not exist are always ready. They are
  // accepted and then dropped, because no lane matches the index.
  always_comb begin
    cfg_ready_out = 1'b1;
    for (int i = 0; i < NUM_CH; i++)
      if (cfg_ch_in == CH_W'(i)) cfg_ready_out = !pend[i];
  end

  assign cfg_acc     = cfg_valid_in && cfg_ready_out;
  assign div_clamped = (cfg_div_in < DIV_W'(2)) ? DIV_W'(2) : cfg_div_in;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_enable_ch #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .sync_i     (sync_in),
      .wr_i       (cfg_acc && (cfg_ch_in == CH_W'(g))),
      .wr_div_i   (div_clamped),
`ifdef CLKGEN_PHASE_EN
      .wr_phase_i (cfg_phase_in),
`endif
      .tick_o     (tick_out[g]),
      .clk_o      (clk_out[g]),
      .pend_o     (pend[g])
    );
  end

endmodule

// File: doc/clk_enable_gen.md
# clk_enable_gen

Multi-channel, runtime-programmable clock-enable generator for the audio datapath. It derives NUM_CH independent divided rates (sample strobe, bit-clock enable, LED/UI tick, …) from the single system clock. Each channel emits a one-cycle tick and a near-50% square wave. Divisor changes land only on period boundaries, so they are glitch-free, and a global sync input phase-aligns all channels. The block sits beside the codec interface and feeds clock enables, not derived clocks, to downstream logic.

## Interface
- NUM_CH, default 4: number of independent channels.
- DIV_W, default 16: divisor and counter width; legal divisors are 2..2^DIV_W-1.
- DEFAULT_DIV, default 4: divisor loaded into every channel at reset; must be ≥2.
- CH_W, derived as max(1, $clog2(NUM_CH)): channel-select width. It is a localparam.

- clk_in, input, 1: system clock (100 MHz).
- rst_in, input, 1: reset, asynchronous, active-high.
- cfg_valid_in, input, 1: a divisor write is offered.
- cfg_ready_out, output, 1: the write can be accepted this cycle. This output is combinational.
- cfg_ch_in, input, CH_W: target channel of the write.
- cfg_div_in, input, DIV_W: new divisor for that channel.
- sync_in, input, 1: realigns all channels when sampled high.
- tick_out, output, NUM_CH: per-channel one-cycle strobe at the start of each period. It is registered.
- clk_out, output, NUM_CH: per-channel square wave. It is registered.

## Operation
- Per-channel state:
  - div_act (DIV_W): the active divisor D.
  - cnt (DIV_W).
  - pend (1 bit).
  - div_pend (DIV_W).
- Reset (asynchronous, immediate):
  - tick_out=0 and clk_out=0.
  - div_act=DEFAULT_DIV.
  - cnt=DEFAULT_DIV-1.
  - pend=0 and div_pend=0.
- Each edge, per channel:
  - Wrap: if cnt==D-1, then cnt_next=0. If pend=1, then div_act←div_pend and pend←0.
  - Otherwise cnt_next=cnt+1.
  - Let D' be the divisor in force after the edge.
  - tick_out←(cnt_next==0).
  - clk_out←(cnt_next < ceil(D'/2)).
- Resulting waveform:
  - clk_out is high for ceil(D/2) cycles and low for floor(D/2) cycles.
  - Even D gives exactly 50% duty; odd D is high one cycle longer.
- Config handshake:
  - cfg_ready_out = !pend[cfg_ch_in] when cfg_ch_in < NUM_CH.
  - cfg_ready_out = 1 when cfg_ch_in ≥ NUM_CH; such writes are accepted and discarded.
  - A write is accepted on an edge with cfg_valid_in && cfg_ready_out. The block then sets pend←1 and div_pend←(cfg_div_in<2 ? 2 : cfg_div_in).
  - Only one pending write per channel is held. Further writes to that channel stall (ready low) until the pending value is applied.
- Write and wrap on the same edge, same channel, pend=0: the write goes to pend. It applies at the following wrap, not this one.
- sync_in high at an edge, for all channels:
  - sync takes priority over counting.
  - cnt_next=0.
  - Any pend is applied immediately (div_act←div_pend, pend←0).
  - Outputs follow the normal rule, so every tick_out=1 and every clk_out=1 on the next cycle.
- sync_in and an accepted write on the same edge: the write is held as pending. It is not applied by that sync.
- Channels are fully independent except for sync_in and the shared config port.

## Timing
- After rst_in deasserts, the first edge produces tick_out=1 and clk_out=1 on every channel.
- Tick period is exactly D cycles. tick_out is never high on two consecutive cycles, since D≥2.
- Latency from sync_in sampled high to tick_out: 1 cycle.
- Divisor change latency: takes effect at the first wrap after acceptance. The old period always completes with no truncated or stretched period.
- cfg_ready_out is combinational from cfg_ch_in and registered pend, so it has no same-cycle dependence on cfg_valid_in.
- rst_in asserted mid-period forces outputs low within the same cycle (asynchronously) and discards pending writes.

## Configuration
- CLKGEN_PHASE_EN defined:
  - Adds input cfg_phase_in (DIV_W), written together with cfg_div_in into a per-channel phase_pend/phase_act pair.
  - On sync_in, a channel loads cnt_next=phase (phase ≥ D is treated as 0).
  - tick_out and clk_out then follow the normal cnt_next rule, so channels can be skewed by a fixed number of cycles.
  - The reset phase is 0.
- CLKGEN_PHASE_EN undefined: the port is absent, no phase storage exists, and sync_in always loads cnt_next=0.

## Test plan
- Reset release with DEFAULT_DIV=4 → tick_out[0] high on cycles 1, 5, 9. clk_out[0] is 1,1,0,0 repeating.
- Write D=5 to ch1 → after the current period ends: tick every 5 cycles, clk_out high for 3 cycles and low for 2.
- Write D=3 to ch2 mid-period → cfg_ready_out low for ch2 until the wrap; a second write to ch2 stalls; a concurrent write to ch3 is accepted. Ch2 then ticks every 3 cycles.
- Write cfg_div_in=0 and cfg_div_in=1 → channel runs with D=2 (tick every 2 cycles, clk_out toggles each cycle).
- sync_in pulse at cnt=2 of channels with D=4 and D=7 → all tick_out high on the next cycle, then periods restart from 0. Under CLKGEN_PHASE_EN with phase=3 on D=7: that channel ticks 4 cycles after the sync edge.
- rst_in asserted mid-period with a pending write → outputs 0 immediately. After release, the channel runs at DEFAULT_DIV and the pending divisor is lost.
